// File: rtl/seanetnackgenerator_ddr_bmpcmd_gen_if.sv
// Event and DDR bitmap-command signal bundle for the bitmap command generator.
// slave is the generator side; master is the feeder/DDR-arbiter side.
interface seanetnackgenerator_ddr_bmpcmd_gen_if #(
  parameter int unsigned FLOW_ID_WIDTH = 10,
  parameter int unsigned SEQ_WIDTH     = 32
);
  logic [FLOW_ID_WIDTH-1:0] evt_flow_id;
  logic [SEQ_WIDTH-1:0]     evt_seq;
  logic                     evt_op;
  logic                     evt_valid;
  logic                     evt_ready;
  logic                     flush;

  logic [31:0]              ddr_cmd_addr;
  logic [511:0]             ddr_cmd_data;
  logic [1:0]               ddr_cmd_type;
  logic [7:0]               ddr_cmd_len;
  logic                     ddr_cmd_valid;
  logic                     ddr_cmd_ready;

  modport master (
    output evt_flow_id, evt_seq, evt_op, evt_valid, flush, ddr_cmd_ready,
    input  evt_ready, ddr_cmd_addr, ddr_cmd_data, ddr_cmd_type, ddr_cmd_len, ddr_cmd_valid
  );

  modport slave (
    input  evt_flow_id, evt_seq, evt_op, evt_valid, flush, ddr_cmd_ready,
    output evt_ready, ddr_cmd_addr, ddr_cmd_data, ddr_cmd_type, ddr_cmd_len, ddr_cmd_valid
  );
endinterface

// File: rtl/seanetnackgenerator_ddr_bmpcmd_gen.sv
// Turns per-packet set/clear sequence events into 512-bit DDR bitmap line commands,
// coalescing consecutive events on the same line and op into one command.
module seanetnackgenerator_ddr_bmpcmd_gen #(
  parameter int unsigned FLOW_ID_WIDTH = 10,
  parameter int unsigned SEQ_WIDTH     = 32,
  parameter int unsigned WIN_LOG2      = 16,
  parameter logic [31:0] BMP_BASE_ADDR = 32'h0,
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst,
  seanetnackgenerator_ddr_bmpcmd_gen_if.slave  bus,
  output logic [31:0]                          dfx_sta0,
  output logic [31:0]                          dfx_sta1,
  output logic [31:0]                          dfx_sta2
);

  localparam int unsigned AgeW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(FLUSH_TIMEOUT);

  typedef enum logic [0:0] {StEmpty, StAccum} state_e;

  state_e          state_q, state_d;

  logic [31:0]     pend_addr_q, pend_addr_d;
  logic [511:0]    pend_mask_q, pend_mask_d;
  logic [1:0]      pend_type_q, pend_type_d;
  logic [AgeW-1:0] pend_age_q, pend_age_d;
  logic            flush_req_q, flush_req_d;

  logic            cmd_valid_q, cmd_valid_d;
  logic [31:0]     cmd_addr_q, cmd_addr_d;
  logic [511:0]    cmd_data_q, cmd_data_d;
  logic [1:0]      cmd_type_q, cmd_type_d;

  logic [31:0]     sta0_q, sta0_d;
  logic [31:0]     sta1_q, sta1_d;
  logic [31:0]     sta2_q, sta2_d;

  logic [63:0]     seq_win;
  logic [31:0]     evt_addr;
  logic [511:0]    evt_mask;
  logic [1:0]      evt_type;

  logic            out_free;
  logic            hit;
  logic            due;
  logic            evt_ready_int;
  logic            accept;
  logic            drain;
  logic            load;

  // Seq bits above the window alias onto the same line.
  always_comb begin
    seq_win  = 64'(bus.evt_seq) & ((64'd1 << WIN_LOG2) - 64'd1);
    evt_addr = BMP_BASE_ADDR
             + 32'(64'(bus.evt_flow_id) << (WIN_LOG2 - 3))
             + 32'((seq_win >> 9) << 6);
    evt_mask = 512'd1 << bus.evt_seq[8:0];
    evt_type = {1'b0, bus.evt_op};
  end

  // Decode and next-state.
  always_comb begin
    out_free      = ~cmd_valid_q | bus.ddr_cmd_ready;
    hit           = (state_q == StAccum) && (evt_addr == pend_addr_q) &&
                    (evt_type == pend_type_q);
    due           = (pend_age_q == AgeMax) | flush_req_q;
    evt_ready_int = ~sys_rst & ((state_q == StEmpty) | hit | out_free);
    accept        = bus.evt_valid & evt_ready_int;
    load          = accept & ~hit;
    // A miss displaces PEND into OUT; otherwise PEND leaves only when due and OUT can take it.
    drain         = (state_q == StAccum) & out_free & (load | due);

    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StAccum;
      StAccum: if (drain && !load) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Datapath and output next-state.
  always_comb begin
    pend_addr_d = pend_addr_q;
    pend_mask_d = pend_mask_q;
    pend_type_d = pend_type_q;
    pend_age_d  = pend_age_q;

    if (load) begin
      pend_addr_d = evt_addr;
      pend_mask_d = evt_mask;
      pend_type_d = evt_type;
      pend_age_d  = '0;
    end else if (accept) begin
      pend_mask_d = pend_mask_q | evt_mask;
    end else if ((state_q == StAccum) && (pend_age_q != AgeMax)) begin
      pend_age_d = pend_age_q + 1'b1;
    end

    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_type_d  = cmd_type_q;
    if (drain) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = pend_addr_q;
      // A hit coinciding with the drain is merged into the outgoing line.
      cmd_data_d  = pend_mask_q | ((accept & hit) ? evt_mask : 512'd0);
      cmd_type_d  = pend_type_q;
    end else if (bus.ddr_cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    flush_req_d = (state_q == StAccum) & ~drain & (flush_req_q | bus.flush);

    sta0_d = sta0_q + 32'(accept);
    sta1_d = sta1_q + 32'(cmd_valid_q & bus.ddr_cmd_ready);
    sta2_d = sta2_q + 32'(accept & hit);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StEmpty;
      pend_addr_q <= '0;
      pend_mask_q <= '0;
      pend_type_q <= '0;
      pend_age_q  <= '0;
      flush_req_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_type_q  <= '0;
      sta0_q      <= '0;
      sta1_q      <= '0;
      sta2_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_mask_q <= pend_mask_d;
      pend_type_q <= pend_type_d;
      pend_age_q  <= pend_age_d;
      flush_req_q <= flush_req_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_type_q  <= cmd_type_d;
      sta0_q      <= sta0_d;
      sta1_q      <= sta1_d;
      sta2_q      <= sta2_d;
    end
  end

  assign bus.evt_ready     = evt_ready_int;
  assign bus.ddr_cmd_valid = cmd_valid_q;
  assign bus.ddr_cmd_addr  = cmd_addr_q;
  assign bus.ddr_cmd_data  = cmd_data_q;
  assign bus.ddr_cmd_type  = cmd_type_q;
  assign bus.ddr_cmd_len   = 8'd0;

  assign dfx_sta0 = sta0_q;
  assign dfx_sta1 = sta1_q;
  assign dfx_sta2 = sta2_q;

endmodule

// File: tb/tb_seanetnackgenerator_ddr_bmpcmd_gen.sv
// Scoreboard bench for the bitmap command generator: a line-level reference model
// predicts commands and handshake timing; a monitor compares every cycle.
module tb_seanetnackgenerator_ddr_bmpcmd_gen;

  localparam int          T    = 16;
  localparam int          WIN  = 16;
  localparam logic [31:0] BASE = 32'h0;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
    logic [1:0]   typ;
  } cmd_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [31:0] dfx0, dfx1, dfx2;

  always #5 sys_clk = ~sys_clk;

  seanetnackgenerator_ddr_bmpcmd_gen_if bus ();

  seanetnackgenerator_ddr_bmpcmd_gen dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .dfx_sta0 (dfx0),
    .dfx_sta1 (dfx1),
    .dfx_sta2 (dfx2)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int stall = 0;
  int rdy_pct = 100;

  cmd_t exp_q[$];
  cmd_t seen_q[$];

  // Reference model: one open line (the coalescing window) plus expected output queue.
  bit           m_open = 1'b0;
  logic [31:0]  m_addr;
  logic [511:0] m_mask;
  logic [1:0]   m_type;
  int           m_age = 0;
  bit           m_freq = 1'b0;
  int unsigned  c0 = 0, c1 = 0, c2 = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] line_addr(input logic [9:0] flow, input logic [31:0] seq);
    longint unsigned s, a;
    s = longint'(seq) % (64'd1 << WIN);
    a = longint'(BASE) + longint'(flow) * (64'd1 << (WIN - 3)) + (s / 512) * 64;
    return 32'(a);
  endfunction

  function automatic bit model_free();
    return (exp_q.size() == 0) || bus.ddr_cmd_ready;
  endfunction

  function automatic bit model_ready();
    logic [31:0] a;
    if (sys_rst) return 1'b0;
    if (!m_open) return 1'b1;
    a = line_addr(bus.evt_flow_id, bus.evt_seq);
    if (a == m_addr && {1'b0, bus.evt_op} == m_type) return 1'b1;
    return model_free();
  endfunction

  task automatic model_step();
    bit acc, hit, free, due, move, was_open;
    logic [31:0] a;
    logic [511:0] bm;
    logic [1:0] ty;
    cmd_t c;
    if (sys_rst) begin
      m_open = 1'b0; m_freq = 1'b0; m_age = 0;
      exp_q.delete();
      c0 = 0; c1 = 0; c2 = 0;
      return;
    end
    a  = line_addr(bus.evt_flow_id, bus.evt_seq);
    bm = '0;
    bm[bus.evt_seq[8:0]] = 1'b1;
    ty = {1'b0, bus.evt_op};
    free     = model_free();
    was_open = m_open;
    hit  = m_open && a == m_addr && ty == m_type;
    acc  = bus.evt_valid && (!m_open || hit || free);
    due  = m_open && (m_age >= T || m_freq);
    move = 1'b0;
    if (acc) c0++;
    if (acc && hit) begin
      m_mask |= bm;
      c2++;
      move = due && free;
    end else if (acc) begin
      move = m_open;
    end else if (m_open) begin
      if (due && free) move = 1'b1;
      else if (m_age < T) m_age++;
    end
    if (move) begin
      c.addr = m_addr; c.data = m_mask; c.typ = m_type;
      exp_q.push_back(c);
    end
    if (acc && !hit) begin
      m_open = 1'b1; m_addr = a; m_mask = bm; m_type = ty; m_age = 0;
    end else if (move) begin
      m_open = 1'b0;
    end
    if (!was_open || move) m_freq = 1'b0;
    else if (bus.flush) m_freq = 1'b1;
  endtask

  // Monitor: checks ready, counters and the output stage against the model, pops on handshake.
  initial forever begin
    @(negedge sys_clk);
    #2;
    if (chk_en) begin
      check("evt_ready", bus.evt_ready, model_ready());
      check("dfx_sta0", dfx0, c0);
      check("dfx_sta1", dfx1, c1);
      check("dfx_sta2", dfx2, c2);
      check("ddr_cmd_len", bus.ddr_cmd_len, 0);
      if (exp_q.size() > 0) begin
        check("ddr_cmd_valid", bus.ddr_cmd_valid, 1);
        check("ddr_cmd_addr", bus.ddr_cmd_addr, exp_q[0].addr);
        check("ddr_cmd_data", bus.ddr_cmd_data, exp_q[0].data);
        check("ddr_cmd_type", bus.ddr_cmd_type, exp_q[0].typ);
      end else begin
        check("ddr_cmd_valid_idle", bus.ddr_cmd_valid, 0);
      end
    end
    if (exp_q.size() > 0 && bus.ddr_cmd_ready) begin
      cmd_t c;
      c.addr = bus.ddr_cmd_addr; c.data = bus.ddr_cmd_data; c.typ = bus.ddr_cmd_type;
      seen_q.push_back(c);
      void'(exp_q.pop_front());
      c1++;
    end
  end

  initial forever begin
    @(negedge sys_clk);
    #3;
    model_step();
  end

  initial forever begin
    @(negedge sys_clk);
    if (stall > 0) begin
      bus.ddr_cmd_ready = 1'b0;
      stall--;
    end else begin
      bus.ddr_cmd_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      bus.evt_valid = 1'b0;
      bus.flush     = 1'b0;
    end
  endtask

  task automatic drive_evt(input int flow, input logic [31:0] seq, input bit op, input bit fl);
    @(negedge sys_clk);
    bus.evt_valid   = 1'b1;
    bus.evt_flow_id = 10'(flow);
    bus.evt_seq     = seq;
    bus.evt_op      = op;
    bus.flush       = fl;
    #1;
  endtask

  task automatic wait_acc();
    int k = 0;
    while (!bus.evt_ready && k < 300) begin
      @(negedge sys_clk);
      bus.flush = 1'b0;
      #1;
      k++;
    end
    if (k == 300) begin
      n_vec++;
      n_err++;
      $display("FAIL evt_accept_timeout: got no evt_ready, expected accept within 300 cycles");
    end
  endtask

  task automatic send(input int flow, input logic [31:0] seq, input bit op, input bit fl = 1'b0);
    drive_evt(flow, seq, op, fl);
    wait_acc();
  endtask

  initial begin
    int hs;
    logic [511:0] m;
    logic [31:0] base_s [4];
    int a_done;
    a_done = 0;
    bus.evt_valid = 1'b0; bus.evt_flow_id = '0; bus.evt_seq = '0; bus.evt_op = 1'b0;
    bus.flush = 1'b0; bus.ddr_cmd_ready = 1'b1;

    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk_en  = 1'b1;
    #2;
    check("rst_valid", bus.ddr_cmd_valid, 0);
    check("rst_addr", bus.ddr_cmd_addr, 0);
    check("rst_data", bus.ddr_cmd_data, 0);
    check("rst_type", bus.ddr_cmd_type, 0);
    check("rst_dfx0", dfx0, 0);

    // Four set events on one line coalesce into one command after the timeout.
    for (int i = 0; i < 4; i++) send(3, 32'(i), 1'b1);
    idle(T + 6);
    #2;
    check("coalesce_dfx0", dfx0, 4);
    check("coalesce_dfx1", dfx1, 1);
    check("coalesce_dfx2", dfx2, 3);
    check("coalesce_cnt", seen_q.size(), 1);
    if (seen_q.size() >= 1) begin
      check("coalesce_addr", seen_q[0].addr, 32'h6000);
      check("coalesce_data", seen_q[0].data, 512'hF);
      check("coalesce_type", seen_q[0].typ, 2'b01);
    end

    // Line boundary: seq 511 and 512 land on adjacent lines.
    seen_q.delete();
    send(0, 32'd511, 1'b1);
    send(0, 32'd512, 1'b1);
    idle(T + 6);
    check("boundary_cnt", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      m = '0; m[511] = 1'b1;
      check("boundary_addr0", seen_q[0].addr, 32'h0);
      check("boundary_data0", seen_q[0].data, m);
      check("boundary_addr1", seen_q[1].addr, 32'h40);
      check("boundary_data1", seen_q[1].data, 512'h1);
    end

    // Set then clear of the same bit never merge.
    seen_q.delete();
    send(0, 32'd5, 1'b1);
    send(0, 32'd5, 1'b0);
    idle(T + 6);
    check("setclr_cnt", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      check("setclr_type0", seen_q[0].typ, 2'b01);
      check("setclr_type1", seen_q[1].typ, 2'b00);
      check("setclr_addr", seen_q[1].addr, seen_q[0].addr);
    end

    // Stalled output: third missing event is back-pressured, nothing lost afterwards.
    seen_q.delete();
    stall = 40;
    send(1, 32'h000, 1'b1);
    send(1, 32'h200, 1'b1);
    drive_evt(1, 32'h400, 1'b1, 1'b0);
    check("stall_evt_ready", bus.evt_ready, 0);
    wait_acc();
    idle(T + 10);
    check("stall_cnt", seen_q.size(), 3);

    // Flush one cycle after a lone event: valid two cycles after the flush.
    send(2, 32'd100, 1'b1);
    @(negedge sys_clk); bus.evt_valid = 1'b0; bus.flush = 1'b1;
    @(negedge sys_clk); bus.flush = 1'b0; #2;
    check("flush_lat_c2", bus.ddr_cmd_valid, 0);
    @(negedge sys_clk); #2;
    check("flush_lat_c3", bus.ddr_cmd_valid, 1);
    idle(3);

    // Hit in the timeout cycle is merged into the outgoing command.
    seen_q.delete();
    send(2, 32'd7, 1'b1);
    idle(T);
    send(2, 32'd9, 1'b1);
    idle(4);
    m = '0; m[7] = 1'b1; m[9] = 1'b1;
    check("to_hit_cnt", seen_q.size(), 1);
    if (seen_q.size() >= 1) check("to_hit_data", seen_q[0].data, m);

    // Reset while a line is pending and OUT holds a stalled command.
    stall = 20;
    send(4, 32'h0, 1'b1);
    send(4, 32'h200, 1'b1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    bus.evt_flow_id = 10'd4; bus.evt_seq = 32'h400; bus.evt_valid = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0; bus.evt_valid = 1'b0; stall = 0;
    #2;
    check("rst2_valid", bus.ddr_cmd_valid, 0);
    check("rst2_dfx1", dfx1, 0);
    hs = seen_q.size();
    idle(T + 6);
    check("rst2_no_cmd", seen_q.size(), hs);

    // Randomised traffic: few flows, clustered seqs, random high bits, flush and back-pressure.
    rdy_pct = 70;
    for (int f = 0; f < 4; f++) base_s[f] = 32'($urandom_range(0, (1 << WIN) - 64));
    for (int i = 0; i < 1500; i++) begin
      int f;
      logic [31:0] s;
      f = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) base_s[f] = 32'($urandom_range(0, (1 << WIN) - 64));
      s = base_s[f] + 32'($urandom_range(0, 40));
      s[31:16] = 16'($urandom_range(0, 65535));
      send(f * 97, s, ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 25));
      else if ($urandom_range(0, 3) == 0) idle(1);
      a_done++;
    end
    rdy_pct = 100;
    idle(T + 10);
    check("random_drained", exp_q.size(), 0);
    check("random_events", dfx0, c0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
